// File: rtl/serial_pkg.sv
// serial_pkg: shared byte type and default FIFO depth for the serial endpoint.
package serial_pkg;
  typedef logic [7:0] byte_t;
  localparam int SERIAL_FIFO_DEPTH = 8;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO; push refused when full, pop ignored when empty.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = SERIAL_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  byte_t                    data_in,
  output byte_t                    data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  byte_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign data_out = mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/serial_endpoint.sv
// serial_endpoint: RX/TX byte FIFOs between a processor and a host port.
// Optional SERIAL_LOOPBACK_EN adds loopback_in, routing TX bytes straight into RX.
module serial_endpoint
  import serial_pkg::*;
#(
  parameter int DEPTH = SERIAL_FIFO_DEPTH
) (
  input  logic  clock,
  input  logic  reset,
`ifdef SERIAL_LOOPBACK_EN
  input  logic  loopback_in,
`endif
  input  byte_t proc_data_in,
  input  logic  proc_wren_in,
  input  logic  proc_rden_in,
  output byte_t proc_data_out,
  output logic  proc_valid_out,
  output logic  proc_ready_out,
  input  byte_t host_rx_data_in,
  input  logic  host_rx_valid_in,
  output logic  host_rx_ready_out,
  output byte_t host_tx_data_out,
  output logic  host_tx_valid_out,
  input  logic  host_tx_ready_in,
  output logic  overflow_out
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic lb;
  logic rx_full, rx_empty, tx_full, tx_empty, rx_push, tx_pop, lb_move;
  byte_t rx_head, tx_head, rx_in;
  logic [CW-1:0] rx_count, tx_count;
`ifdef SERIAL_LOOPBACK_EN
  assign lb = loopback_in;
`else
  assign lb = 1'b0;
`endif
  assign lb_move = lb && !tx_empty && !rx_full;
  assign rx_push = lb ? lb_move : host_rx_valid_in;
  assign rx_in = lb ? tx_head : host_rx_data_in;
  assign tx_pop = lb ? lb_move : host_tx_ready_in;
  assign host_rx_ready_out = !lb && !rx_full;
  assign host_tx_valid_out = !lb && !tx_empty;
  assign proc_valid_out = !rx_empty;
  assign proc_ready_out = !tx_full;
  // storage is unreset, so heads are masked to zero while their FIFO is empty
  assign proc_data_out = rx_count != '0 ? rx_head : 8'h00;
  assign host_tx_data_out = tx_count != '0 ? tx_head : 8'h00;
  always_ff @(posedge clock)
    if (reset) overflow_out <= 1'b0;
    else if (proc_wren_in && tx_full) overflow_out <= 1'b1;
  byte_fifo #(.DEPTH(DEPTH)) u_rx (
    .clock(clock), .reset(reset), .push(rx_push), .pop(proc_rden_in),
    .data_in(rx_in), .data_out(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  byte_fifo #(.DEPTH(DEPTH)) u_tx (
    .clock(clock), .reset(reset), .push(proc_wren_in), .pop(tx_pop),
    .data_in(proc_data_in), .data_out(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
endmodule

// File: tb/tb_serial_endpoint.sv
// tb_serial_endpoint: directed self-checking bench for serial_endpoint (DEPTH=8).
module tb_serial_endpoint;
  logic       clock = 1'b0;
  logic       reset;
`ifdef SERIAL_LOOPBACK_EN
  logic       loopback_in;
`endif
  logic [7:0] proc_data_in, proc_data_out, host_rx_data_in, host_tx_data_out;
  logic       proc_wren_in, proc_rden_in, proc_valid_out, proc_ready_out;
  logic       host_rx_valid_in, host_rx_ready_out, host_tx_valid_out, host_tx_ready_in;
  logic       overflow_out;
  int checks = 0;
  int errors = 0;
  serial_endpoint #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset),
`ifdef SERIAL_LOOPBACK_EN
    .loopback_in(loopback_in),
`endif
    .proc_data_in(proc_data_in), .proc_wren_in(proc_wren_in), .proc_rden_in(proc_rden_in),
    .proc_data_out(proc_data_out), .proc_valid_out(proc_valid_out), .proc_ready_out(proc_ready_out),
    .host_rx_data_in(host_rx_data_in), .host_rx_valid_in(host_rx_valid_in),
    .host_rx_ready_out(host_rx_ready_out), .host_tx_data_out(host_tx_data_out),
    .host_tx_valid_out(host_tx_valid_out), .host_tx_ready_in(host_tx_ready_in),
    .overflow_out(overflow_out)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_pvalid"}, proc_valid_out, 0);
    check({tag, "_tvalid"}, host_tx_valid_out, 0);
    check({tag, "_pready"}, proc_ready_out, 1);
    check({tag, "_hready"}, host_rx_ready_out, 1);
    check({tag, "_pdata"}, proc_data_out, 0);
    check({tag, "_tdata"}, host_tx_data_out, 0);
    check({tag, "_ovf"}, overflow_out, 0);
  endtask
  initial begin
    logic [7:0] exp_b;
    reset = 1; proc_data_in = 0; proc_wren_in = 0; proc_rden_in = 0;
    host_rx_data_in = 0; host_rx_valid_in = 0; host_tx_ready_in = 0;
`ifdef SERIAL_LOOPBACK_EN
    loopback_in = 0;
`endif
    step(); step();
    reset = 0;
    check_idle("reset");
    host_rx_valid_in = 1; host_rx_data_in = 8'hA5;
    step();
    check("rx_first_valid", proc_valid_out, 1);
    check("rx_first_data", proc_data_out, 8'hA5);
    host_rx_data_in = 8'h3C;
    step();
    host_rx_valid_in = 0;
    check("rx_head_held", proc_data_out, 8'hA5);
    proc_rden_in = 1;
    step();
    check("rx_second_data", proc_data_out, 8'h3C);
    check("rx_second_valid", proc_valid_out, 1);
    step();
    check("rx_drained_valid", proc_valid_out, 0);
    check("rx_drained_data", proc_data_out, 0);
    step();
    proc_rden_in = 0;
    check("rden_empty_valid", proc_valid_out, 0);
    check("rden_empty_count", dut.u_rx.count, 0);
    for (int i = 1; i <= 8; i++) begin
      proc_wren_in = 1; proc_data_in = 8'(i);
      step();
    end
    check("tx_full_ready", proc_ready_out, 0);
    check("tx_full_ovf_clear", overflow_out, 0);
    check("tx_full_head", host_tx_data_out, 8'h01);
    proc_data_in = 8'hFF;
    step();
    proc_wren_in = 0;
    check("tx_ovf_set", overflow_out, 1);
    check("tx_ovf_count", dut.u_tx.count, 8);
    host_tx_ready_in = 1;
    for (int i = 1; i <= 8; i++) begin
      check("tx_drain_valid", host_tx_valid_out, 1);
      check("tx_drain_data", host_tx_data_out, 32'(i));
      step();
    end
    host_tx_ready_in = 0;
    check("tx_drained_valid", host_tx_valid_out, 0);
    check("tx_ovf_sticky", overflow_out, 1);
    for (int i = 0; i < 4; i++) begin
      proc_wren_in = 1; proc_data_in = 8'(8'h10 + i);
      step();
    end
    check("tx_four_count", dut.u_tx.count, 4);
    host_tx_ready_in = 1;
    exp_b = 8'h10;
    for (int k = 0; k < 10; k++) begin
      proc_data_in = 8'(8'h14 + k);
      check("tx_stream_data", host_tx_data_out, exp_b);
      step();
      exp_b++;
      check("tx_stream_count", dut.u_tx.count, 4);
    end
    proc_wren_in = 0;
    for (int k = 0; k < 4; k++) begin
      check("tx_tail_data", host_tx_data_out, exp_b);
      step();
      exp_b++;
    end
    check("tx_tail_empty", host_tx_valid_out, 0);
    host_tx_ready_in = 0;
    for (int i = 0; i < 8; i++) begin
      proc_wren_in = 1; proc_data_in = 8'(8'h20 + i);
      step();
    end
    proc_data_in = 8'h99; host_tx_ready_in = 1;
    step();
    proc_wren_in = 0; host_tx_ready_in = 0;
    check("full_popush_count", dut.u_tx.count, 7);
    check("full_popush_head", host_tx_data_out, 8'h21);
    check("full_popush_ready", proc_ready_out, 1);
    reset = 1;
    step();
    reset = 0;
    check("rst_clear_ovf", overflow_out, 0);
    for (int i = 0; i < 3; i++) begin
      proc_wren_in = 1; proc_data_in = 8'(8'h40 + i);
      host_rx_valid_in = 1; host_rx_data_in = 8'(8'h50 + i);
      step();
    end
    check("pre_rst_rx_count", dut.u_rx.count, 3);
    check("pre_rst_tx_count", dut.u_tx.count, 3);
    check("pre_rst_rx_head", proc_data_out, 8'h50);
    reset = 1; proc_rden_in = 1; host_tx_ready_in = 1;
    step();
    reset = 0; proc_wren_in = 0; host_rx_valid_in = 0; proc_rden_in = 0; host_tx_ready_in = 0;
    check_idle("midrst");
    check("midrst_rx_count", dut.u_rx.count, 0);
    check("midrst_tx_count", dut.u_tx.count, 0);
`ifdef SERIAL_LOOPBACK_EN
    begin
      logic seen_tx;
      logic got;
      seen_tx = 0; got = 0;
      loopback_in = 1;
      check("lb_hready", host_rx_ready_out, 0);
      proc_wren_in = 1; proc_data_in = 8'h5A;
      step();
      proc_wren_in = 0;
      for (int c = 0; c < 2 && !got; c++) begin
        if (host_tx_valid_out) seen_tx = 1;
        step();
        if (proc_valid_out && proc_data_out == 8'h5A) got = 1;
      end
      check("lb_arrived", got, 1);
      check("lb_tx_quiet", seen_tx | host_tx_valid_out, 0);
      loopback_in = 0;
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_endpoint.md
SERIAL_ENDPOINT -- requirements
Module: serial_endpoint

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entries per byte FIFO (power of two, >=2).
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port proc_data_in  input  8  byte written by processor (processor serial_out).
REQ-005 SHALL have port proc_wren_in  input  1  processor write strobe (processor serial_wren_out).
REQ-006 SHALL have port proc_rden_in  input  1  processor read-consume strobe (processor serial_rden_out).
REQ-007 SHALL have port proc_data_out  output  8  RX head byte (to processor serial_in).
REQ-008 SHALL have port proc_valid_out  output  1  RX byte available (to processor serial_valid_in).
REQ-009 SHALL have port proc_ready_out  output  1  TX FIFO can accept (to processor serial_ready_in).
REQ-010 SHALL have ports host_rx_data_in input 8, host_rx_valid_in input 1, host_rx_ready_out output 1: external byte source.
REQ-011 SHALL have ports host_tx_data_out output 8, host_tx_valid_out output 1, host_tx_ready_in input 1: external byte sink.
REQ-012 SHALL have port overflow_out  output  1  sticky: processor wrote while TX full.

Function
REQ-013 RX push SHALL occur when host_rx_valid_in && host_rx_ready_out; host_rx_ready_out = RX not full.
REQ-014 proc_valid_out SHALL equal RX not empty; proc_data_out SHALL be RX head, 8'h00 when empty.
REQ-015 RX pop SHALL occur when proc_rden_in && proc_valid_out; proc_rden_in while empty SHALL be ignored.
REQ-016 TX push SHALL occur when proc_wren_in && proc_ready_out; proc_ready_out = TX not full.
REQ-017 proc_wren_in while TX full SHALL drop the byte and set overflow_out at next edge, held until reset.
REQ-018 host_tx_valid_out SHALL equal TX not empty; host_tx_data_out = TX head; pop when valid && host_tx_ready_in.
REQ-019 Latency: byte pushed at edge N SHALL appear on consumer outputs after edge N (one cycle), never same cycle.
REQ-020 Simultaneous push and pop on a non-empty, non-full FIFO SHALL both take effect; occupancy unchanged.
REQ-021 On full FIFO, pop with push-attempt: push refused that cycle (ready low); occupancy DEPTH-1 after.
REQ-022 Read/write pointers SHALL be log2(DEPTH) bits wrapping DEPTH-1 -> 0; occupancy counter log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-023 FIFO order SHALL be strict first-in first-out; no byte duplicated or lost except REQ-017 drops.

Reset
REQ-024 Reset SHALL clear both FIFOs' pointers and counts, and overflow_out.
REQ-025 During/after reset: proc_valid_out=0, host_tx_valid_out=0, proc_ready_out=1, host_rx_ready_out=1, data outputs 8'h00.
REQ-026 Reset mid-transfer SHALL discard all buffered bytes; pushes/pops in the reset cycle SHALL be ignored.
REQ-027 Storage array contents SHALL NOT need reset.

Configuration
REQ-028 Macro SERIAL_LOOPBACK_EN, when defined, SHALL add input loopback_in (1 bit).
REQ-029 With macro and loopback_in=1: TX head moves into RX each cycle TX not empty and RX not full; host_tx_valid_out=0, host_rx_ready_out=0.
REQ-030 With macro and loopback_in=0, or macro undefined: behaviour per REQ-013..REQ-023; port loopback_in absent when undefined.

Structure
REQ-031 Package serial_pkg SHALL hold byte typedef (8-bit) and default-depth constant SERIAL_FIFO_DEPTH=8.
REQ-032 Sub-module byte_fifo (parameter DEPTH; push, pop, data in/out, full, empty, count) SHALL be instantiated twice (RX, TX).

Verification
REQ-033 Host pushes 8'hA5, 8'h3C -> proc_valid_out=1 next cycle, proc_data_out=8'hA5; rden -> 8'h3C; rden -> valid=0.
REQ-034 Processor writes 8 bytes 8'h01..8'h08 with host_tx_ready_in=0 -> proc_ready_out=0 after 8th; 9th write 8'hFF dropped, overflow_out=1; drain yields 01..08.
REQ-035 TX holding 4 bytes, simultaneous write and host pop for 10 cycles -> count stays 4, output order preserved across pointer wrap.
REQ-036 rden with RX empty -> no state change, proc_valid_out stays 0, occupancy 0.
REQ-037 Reset asserted with 3 bytes in each FIFO -> next cycle both valids 0, both readies 1, overflow_out 0.
REQ-038 SERIAL_LOOPBACK_EN, loopback_in=1, processor writes 8'h5A -> proc_valid_out=1 with 8'h5A within 2 cycles; host_tx_valid_out never 1.
